keypad_onehot_capture: RTL and testbench
========================================

# keypad_onehot_capture

Upstream front-end for the 8-to-3 encoder stage. Synchronises and debounces eight raw key/switch lines, detects a clean single-key press, and presents it as a registered one-hot vector plus enable with a valid/ready handshake. Multi-key presses are rejected and flagged. Its `onehot`/`en` outputs drive the encoder's `in[7:0]`/`En` inputs directly.

## Interface

Parameters:
- `DEB_CYCLES`, default 16: consecutive stable synchronised samples required before a new key vector is accepted. Legal range ≥ 2.
- `REPEAT_CYCLES`, default 256: hold time before auto-repeat. Used only with the macro in Configuration.

Ports:
- `clk`, input, 1: single clock; all state is on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `key_raw`, input, 8: asynchronous raw key lines, active-high.
- `out_ready`, input, 1: downstream accepts the current code when this and `en` are both high on a rising edge.
- `onehot`, output, 8: registered one-hot key code; exactly one bit set whenever `en`=1.
- `en`, output, 1: valid strobe for `onehot`.
- `multi_err`, output, 1: one-cycle pulse when a debounced vector with more than one bit set is detected.

## Operation

- Synchroniser: two flops per line, `sync1` → `sync2`, both reset to 0.
- Debouncer:
  - Holds `cand[7:0]`, counter `cnt` ($clog2(DEB_CYCLES) bits) and debounced vector `deb[7:0]`. All reset to 0.
  - If `sync2` != `cand`: load `cand` <= `sync2` and `cnt` <= 0.
  - Otherwise, if `cnt` < DEB_CYCLES-1, increment `cnt`.
  - If `cnt` == DEB_CYCLES-1 and `sync2` == `cand`: load `deb` <= `cand` (idempotent while stable).
  - Any bounce restarts the count.
- FSM states: IDLE, PRESS, HOLD. Reset state is IDLE.
- IDLE:
  - `deb` popcount == 1: load `onehot` <= `deb`, assert `en`, go to PRESS.
  - `deb` popcount ≥ 2: pulse `multi_err`, go to HOLD.
  - `deb` == 0: stay in IDLE.
- PRESS:
  - Hold `en`=1 and `onehot` stable until `out_ready`=1.
  - On handshake: `en` <= 0 on the next edge, go to HOLD.
  - Key release or change during PRESS does not alter or drop the pending code.
- HOLD:
  - Wait for `deb` == 0, then go to IDLE. No output while waiting.
  - A second key added while holding is ignored and does not set `multi_err`.
- `onehot` keeps its last value after a handshake. Its value is meaningful only while `en`=1.
- Reset mid-PRESS: `en` and `onehot` clear immediately. The code is lost and is not re-emitted unless the key is re-debounced from scratch.

## Timing

- Reset values: `onehot`=8'h00, `en`=0, `multi_err`=0.
- Press latency: `key_raw` changes just after edge 0 and stays stable.
  - `sync2` updates at edge 2.
  - `cand` loads at edge 3.
  - `deb` updates at edge 3+DEB_CYCLES.
  - `en` rises at edge 4+DEB_CYCLES, i.e. edge 20 with the default.
- `en` falls on the edge after the handshake edge; it is never high for fewer than 1 cycle.
- Release-to-IDLE latency is likewise 3+DEB_CYCLES edges, plus 1 edge for the FSM.
- `multi_err` is high for exactly one cycle, on edge 4+DEB_CYCLES.
- Minimum period between two accepted presses: release debounce plus press debounce.

## Configuration

- `KEYCAP_AUTOREPEAT_EN` defined:
  - HOLD contains a repeat counter of $clog2(REPEAT_CYCLES) bits, cleared on HOLD entry.
  - While `deb` is unchanged with popcount 1, the counter increments.
  - At REPEAT_CYCLES-1 the FSM re-loads `onehot` <= `deb`, asserts `en`, and goes to PRESS.
  - Any change of `deb` clears the counter.
  - HOLD entered via `multi_err` never repeats.
- `KEYCAP_AUTOREPEAT_EN` undefined:
  - No repeat counter is present.
  - A held key produces exactly one code.

## Structure

- Shared package `keypad_pkg` contains:
  - the FSM state typedef (IDLE/PRESS/HOLD),
  - the width constant 8 for the key vector,
  - a popcount/onehot-check function shared with bench checkers.
- One sub-module, `key_debouncer`: the synchroniser, `cand`/`cnt` and `deb` register, parameterised by DEB_CYCLES. The FSM and the optional repeat logic stay in the top module.

## Test plan

1. Reset:
   - Stimulus: assert `rst_n`=0 with `key_raw`=8'hFF.
   - Required: `onehot`=0, `en`=0 and `multi_err`=0 throughout.
   - After release with `key_raw`=0: still no `en`.
2. Clean press:
   - Stimulus: `key_raw`=8'h04, `out_ready`=1.
   - Required: `en` high for exactly 1 cycle at edge 20 with `onehot`=8'h04. No further `en` while held, without macro.
3. Bounce:
   - Stimulus: toggle bit 5 every 10 cycles for 60 cycles, then hold it steady.
   - Required: no `en` during toggling; a single `en` with `onehot`=8'h20 at 20 edges after the last toggle.
4. Backpressure:
   - Stimulus: press 8'h80 with `out_ready`=0 for 30 cycles and release the key after 5 of those cycles.
   - Required: `en`=1 and `onehot`=8'h80 held stable until `out_ready`=1, then `en` falls on the next edge.
5. Multi-key:
   - Stimulus: `key_raw`=8'h03.
   - Required: `multi_err` 1-cycle pulse at edge 20 and no `en`.
   - Then release and press 8'h01: normal code.
6. Auto-repeat (`KEYCAP_AUTOREPEAT_EN`, REPEAT_CYCLES=8):
   - Stimulus: hold 8'h10 with `out_ready`=1.
   - Required: `en` pulses are 9 cycles apart (8 in HOLD + 1 in PRESS).
   - Reset asserted mid-hold clears `en` immediately.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad one-hot capture front-end.
// Used by the RTL and by bench checkers.
package keypad_pkg;

   localparam int KEY_W = 8;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_PRESS = 2'd1;
   localparam state_t ST_HOLD  = 2'd2;

   function automatic logic [3:0] popcount(input logic [KEY_W-1:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < KEY_W; i++) begin
         c = c + {3'b000, v[i]};
      end
      return c;
   endfunction

   function automatic logic is_onehot(input logic [KEY_W-1:0] v);
      return popcount(v) == 4'd1;
   endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchroniser plus stable-count debouncer for the key lines.
// deb only follows sync2 after DEB_CYCLES identical samples.
module key_debouncer
   import keypad_pkg::*;
#(
   parameter int DEB_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [KEY_W-1:0] key_raw,
   output logic [KEY_W-1:0] deb
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

   logic [KEY_W-1:0] sync1;
   logic [KEY_W-1:0] sync2;
   logic [KEY_W-1:0] cand;
   logic [CW-1:0]    cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         cand  <= '0;
         cnt   <= '0;
         deb   <= '0;
      end else begin
         sync1 <= key_raw;
         sync2 <= sync1;
         if (sync2 != cand) begin
            cand <= sync2;
            cnt  <= '0;
         end else begin
            if (cnt < CMAX) begin
               cnt <= cnt + 1'b1;
            end
            if (cnt == CMAX) begin
               deb <= cand;
            end
         end
      end
   end

endmodule

// File: rtl/keypad_onehot_capture.sv
// Debounced single-key capture with valid/ready one-hot output.
// Optional auto-repeat in HOLD: define KEYCAP_AUTOREPEAT_EN.
module keypad_onehot_capture
   import keypad_pkg::*;
#(
   parameter int DEB_CYCLES    = 16,
   parameter int REPEAT_CYCLES = 256
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [KEY_W-1:0] key_raw,
   input  logic             out_ready,
   output logic [KEY_W-1:0] onehot,
   output logic             en,
   output logic             multi_err
);

   if (DEB_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
      $error("keypad_onehot_capture: DEB_CYCLES and REPEAT_CYCLES must be >= 2");
   end

   logic [KEY_W-1:0] deb;
   logic [3:0]       deb_pop;
   state_t           state;

   key_debouncer #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_raw (key_raw),
      .deb     (deb)
   );

   assign deb_pop = popcount(deb);

`ifdef KEYCAP_AUTOREPEAT_EN
   localparam int RW = $clog2(REPEAT_CYCLES);
   localparam logic [RW-1:0] RMAX = RW'(REPEAT_CYCLES - 1);

   logic [RW-1:0]    rpt;
   logic             rpt_ok;
   logic [KEY_W-1:0] deb_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         onehot    <= '0;
         en        <= 1'b0;
         multi_err <= 1'b0;
         rpt       <= '0;
         rpt_ok    <= 1'b0;
         deb_prev  <= '0;
      end else begin
         multi_err <= 1'b0;
         deb_prev  <= deb;
         case (state)
            ST_IDLE: begin
               if (deb_pop == 4'd1) begin
                  onehot <= deb;
                  en     <= 1'b1;
                  state  <= ST_PRESS;
               end else if (deb_pop >= 4'd2) begin
                  multi_err <= 1'b1;
                  rpt       <= '0;
                  rpt_ok    <= 1'b0;
                  state     <= ST_HOLD;
               end
            end
            ST_PRESS: begin
               if (out_ready) begin
                  en     <= 1'b0;
                  rpt    <= '0;
                  rpt_ok <= 1'b1;
                  state  <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (deb == '0) begin
                  state <= ST_IDLE;
               end else if (deb != deb_prev) begin
                  rpt <= '0;
               end else if (rpt_ok && deb_pop == 4'd1) begin
                  // Repeat fires on the cycle the counter sits at its top value
                  if (rpt == RMAX) begin
                     onehot <= deb;
                     en     <= 1'b1;
                     state  <= ST_PRESS;
                  end else begin
                     rpt <= rpt + 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         onehot    <= '0;
         en        <= 1'b0;
         multi_err <= 1'b0;
      end else begin
         multi_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (deb_pop == 4'd1) begin
                  onehot <= deb;
                  en     <= 1'b1;
                  state  <= ST_PRESS;
               end else if (deb_pop >= 4'd2) begin
                  multi_err <= 1'b1;
                  state     <= ST_HOLD;
               end
            end
            ST_PRESS: begin
               if (out_ready) begin
                  en    <= 1'b0;
                  state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (deb == '0) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_keypad_onehot_capture.sv
// Directed bench for keypad_onehot_capture (default and auto-repeat builds).
// Expected edge numbers are counted from the edge after which key_raw changes.
module tb_keypad_onehot_capture;
   import keypad_pkg::*;

`ifdef KEYCAP_AUTOREPEAT_EN
   localparam int RPT = 8;
`else
   localparam int RPT = 256;
`endif

   logic       clk;
   logic       rst_n;
   logic [7:0] key_raw;
   logic       out_ready;
   logic [7:0] onehot;
   logic       en;
   logic       multi_err;

   int checks;
   int failures;

   keypad_onehot_capture #(
      .DEB_CYCLES    (16),
      .REPEAT_CYCLES (RPT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_raw   (key_raw),
      .out_ready (out_ready),
      .onehot    (onehot),
      .en        (en),
      .multi_err (multi_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit rep_hit(int n, int first);
`ifdef KEYCAP_AUTOREPEAT_EN
      return n >= first && ((n - first) % 9) == 0;
`else
      return n == first;
`endif
   endfunction

   task automatic settle_release();
      key_raw = 8'h00;
      repeat (40) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      key_raw = 8'hFF;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (onehot !== 8'h00 || en !== 1'b0 || multi_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state cyc=%0d onehot=%h en=%b merr=%b req=00/0/0",
                     i, onehot, en, multi_err);
         end
      end
      @(negedge clk);
      key_raw = 8'h00;
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         checks++;
         if (en !== 1'b0 || multi_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_release cyc=%0d en=%b merr=%b req=0/0",
                     i, en, multi_err);
         end
      end
   endtask

   task automatic test_clean_press();
      bit exp;
      out_ready = 1'b1;
      @(posedge clk); #1;
      key_raw = 8'h04;
      for (int n = 1; n <= 50; n++) begin
         @(posedge clk); #1;
         exp = rep_hit(n, 20);
         checks++;
         if (en !== exp) begin
            failures++;
            $display("FAIL clean_en edge=%0d en=%b req=%b", n, en, exp);
         end
         if (exp) begin
            checks++;
            if (onehot !== 8'h04) begin
               failures++;
               $display("FAIL clean_code edge=%0d onehot=%h req=04", n, onehot);
            end
         end
         checks++;
         if (multi_err !== 1'b0) begin
            failures++;
            $display("FAIL clean_merr edge=%0d merr=%b req=0", n, multi_err);
         end
      end
      settle_release();
   endtask

   task automatic test_bounce();
      bit exp;
      out_ready = 1'b1;
      @(posedge clk); #1;
      for (int n = 0; n <= 120; n++) begin
         if (n > 0) begin
            @(posedge clk); #1;
            exp = rep_hit(n, 80);
            checks++;
            if (en !== exp) begin
               failures++;
               $display("FAIL bounce_en edge=%0d en=%b req=%b", n, en, exp);
            end
            if (exp) begin
               checks++;
               if (onehot !== 8'h20) begin
                  failures++;
                  $display("FAIL bounce_code edge=%0d onehot=%h req=20", n, onehot);
               end
            end
         end
         if (n % 10 == 0 && n <= 60) begin
            key_raw = ((n / 10) % 2 == 0) ? 8'h20 : 8'h00;
         end
      end
      settle_release();
   endtask

   task automatic test_backpressure();
      bit exp;
      out_ready = 1'b0;
      @(posedge clk); #1;
      key_raw = 8'h80;
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk); #1;
         exp = (n >= 20 && n <= 50);
         checks++;
         if (en !== exp) begin
            failures++;
            $display("FAIL bp_en edge=%0d en=%b req=%b", n, en, exp);
         end
         if (exp) begin
            checks++;
            if (onehot !== 8'h80) begin
               failures++;
               $display("FAIL bp_code edge=%0d onehot=%h req=80", n, onehot);
            end
         end
         if (n == 25) key_raw = 8'h00;
         if (n == 50) out_ready = 1'b1;
      end
      settle_release();
   endtask

   task automatic test_multi_key();
      bit exp;
      out_ready = 1'b1;
      @(posedge clk); #1;
      key_raw = 8'h03;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         checks++;
         if (multi_err !== (n == 20)) begin
            failures++;
            $display("FAIL multi_pulse edge=%0d merr=%b req=%b", n, multi_err, n == 20);
         end
         checks++;
         if (en !== 1'b0) begin
            failures++;
            $display("FAIL multi_en edge=%0d en=%b req=0", n, en);
         end
      end
      settle_release();
      key_raw = 8'h01;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         exp = rep_hit(n, 20);
         checks++;
         if (en !== exp) begin
            failures++;
            $display("FAIL multi_next_en edge=%0d en=%b req=%b", n, en, exp);
         end
         if (exp) begin
            checks++;
            if (onehot !== 8'h01) begin
               failures++;
               $display("FAIL multi_next_code edge=%0d onehot=%h req=01", n, onehot);
            end
         end
      end
      settle_release();
   endtask

`ifdef KEYCAP_AUTOREPEAT_EN
   task automatic test_autorepeat();
      bit exp;
      out_ready = 1'b1;
      @(posedge clk); #1;
      key_raw = 8'h10;
      for (int n = 1; n <= 56; n++) begin
         @(posedge clk); #1;
         exp = (n == 20 || n == 29 || n == 38 || n == 47 || n == 56);
         checks++;
         if (en !== exp) begin
            failures++;
            $display("FAIL rpt_en edge=%0d en=%b req=%b", n, en, exp);
         end
         if (exp) begin
            checks++;
            if (onehot !== 8'h10) begin
               failures++;
               $display("FAIL rpt_code edge=%0d onehot=%h req=10", n, onehot);
            end
         end
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (en !== 1'b0 || onehot !== 8'h00) begin
         failures++;
         $display("FAIL rpt_reset en=%b onehot=%h req=0/00", en, onehot);
      end
      key_raw = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
   endtask
`endif

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_clean_press();
      test_bounce();
      test_backpressure();
      test_multi_key();
`ifdef KEYCAP_AUTOREPEAT_EN
      test_autorepeat();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
